// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
// opcode/funct constants, ALU codes, mux selects and the control-word struct.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IEXEC   = 4'd10,
        S_IWB     = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational R-type funct lookup: ALU control code plus a valid flag for
// the funct values this datapath supports.
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       valid
);

    always_comb begin
        valid  = 1'b1;
        alu_op = ALU_ADD;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_SLL:  alu_op = ALU_SLL;
            FN_SRL:  alu_op = ALU_SRL;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle MIPS-subset datapath: Moore control word
// per state, memory-ready stalls, and a retired-instruction counter.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCEn,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             Illegal,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] Retired
);

    state_t     state;
    state_t     state_next;
    ctrl_t      ctrl;
    logic [3:0] funct_alu_op;
    logic       funct_valid;
    logic       retire;

    mc_alu_decode u_alu_decode (
        .funct  (Funct),
        .alu_op (funct_alu_op),
        .valid  (funct_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_REXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_IEXEC;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_next = MemReady ? S_FETCH : S_MEMWR;
            S_REXEC:  state_next = funct_valid ? S_RWB : S_ILLEGAL;
            S_IEXEC:  state_next = S_IWB;
            default:  state_next = S_FETCH;
        endcase
    end

    // NOTE: the whole control word is defaulted before the case so every path
    // assigns every field and no latch is inferred.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = MemReady;
                ctrl.pc_write  = MemReady;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_SEXT_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = funct_alu_op;
            end
            S_RWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_source = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_IWB:     ctrl.reg_write = 1'b1;
            S_ILLEGAL: ctrl.illegal   = 1'b1;
            default:   ctrl = '0;
        endcase
    end

    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: retire = 1'b1;
            S_MEMWR: retire = MemReady;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)       Retired <= '0;
        else if (retire) Retired <= Retired + 1'b1;
    end

    assign PCEn     = ctrl.pc_write | (ctrl.branch & Zero);
    assign IorD     = ctrl.iord;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegWrite = ctrl.reg_write;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign PCSource = ctrl.pc_source;
    assign Illegal  = ctrl.illegal;
    assign State    = state;

endmodule
